key_onehot_gen: RTL

KEY_ONEHOT_GEN -- requirements
Module: key_onehot_gen

---
 rtl/key_onehot_gen.sv | 67 ++++++
 1 files changed

// File: rtl/key_onehot_gen.sv
// key_onehot_gen: per-channel synchronize + debounce of 4 key lines; each debounced
// rising edge becomes a one-hot event, issued lowest-index-first through a ready/valid register.
module key_onehot_gen #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    input  logic       out_ready,
    input  logic       clr_ovf,
    output logic [3:0] onehot_out,
    output logic       out_valid,
    output logic [3:0] key_state,
    output logic       ovf
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0]    r_sync1, r_sync2, r_key, r_rise, r_pend, r_onehot;
    logic          r_valid, r_ovf;
    logic [CW-1:0] r_cnt [4];
    logic [3:0]    w_diff, w_done, w_pick, w_clr;
    logic          w_load;

    always_comb begin
        w_diff = r_sync2 ^ r_key;
        w_done = 4'b0;
        for (int i = 0; i < 4; i++)
            w_done[i] = w_diff[i] && (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
        // x & -x isolates the lowest set bit, giving channel 0 top priority
        w_pick = r_pend & (~r_pend + 4'd1);
        w_load = !r_valid || out_ready;
        w_clr  = w_load ? w_pick : 4'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 4'b0;
            r_sync2  <= 4'b0;
            r_key    <= 4'b0;
            r_rise   <= 4'b0;
            r_pend   <= 4'b0;
            r_onehot <= 4'b0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
            r_key   <= r_key ^ w_done;
            r_rise  <= w_done & ~r_key;
            r_pend  <= (r_pend & ~w_clr) | r_rise;
            // a rise landing on a bit being issued this edge re-arms it rather than overflowing
            r_ovf   <= (|(r_rise & r_pend & ~w_clr)) || (r_ovf && !clr_ovf);
            for (int i = 0; i < 4; i++)
                r_cnt[i] <= (w_diff[i] && !w_done[i]) ? r_cnt[i] + 1'b1 : '0;
            if (w_load) begin
                r_onehot <= w_pick;
                r_valid  <= |r_pend;
            end
        end
    end

    assign onehot_out = r_onehot;
    assign out_valid  = r_valid;
    assign key_state  = r_key;
    assign ovf        = r_ovf;
endmodule
